// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field widths and the fetch-stage state type.
package cpu_pkg;
  localparam int OPC_W = 5;
  localparam int REG_W = 5;
  localparam int IMM_W = 22;

  localparam logic [OPC_W-1:0] OPC_NOP = 5'd17;
  localparam logic [OPC_W-1:0] OPC_HLT = 5'd18;
  localparam logic [OPC_W-1:0] OPC_OUT = 5'd20;
  localparam logic [OPC_W-1:0] OPC_LR  = 5'd23;
  localparam logic [OPC_W-1:0] OPC_SW  = 5'd24;
  localparam logic [OPC_W-1:0] OPC_LI  = 5'd25;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for the fetch stage: wrapped increment, jump range check and redirect mux.
module pc_next_calc #(
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 21,
  parameter int RESET_PC  = 0
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_valid_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              jump_oor_o
);
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] RESET_A  = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc     = (pc_i == LAST_PC) ? '0 : pc_i + ADDR_W'(1);
  assign jump_oor_o = (jump_target_i >= DEPTH_A);

  always_comb begin
    pc_next_o = pc_i;
    if (jump_valid_i) begin
      pc_next_o = jump_oor_o ? RESET_A : jump_target_i;
    end else if (advance_i) begin
      pc_next_o = pc_inc;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC + IF/ID register stage in front of a combinational instruction memory.
// Optional per-unit fetch/stall counters are built when FETCH_PERF_COUNT_EN is defined.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INSTR_W    = 32,
  parameter int OPC_W      = 5,
  parameter int MEM_DEPTH  = 21,
  parameter int RESET_PC   = 0,
  parameter int HLT_OPCODE = 18
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  endereco,
  input  logic [INSTR_W-1:0] instrucao,
  input  logic               stall,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               resume,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  output logic               halted,
  output logic               fault
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [ADDR_W-1:0]  fetch_count,
  output logic [ADDR_W-1:0]  stall_count
`endif
);
  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_calc;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;
  logic               is_hlt, in_fetch, capture, advance, jump_oor;

  // Case equality keeps an unknown opcode from being taken as a halt.
  assign is_hlt   = (instrucao[INSTR_W-1 -: OPC_W] === OPC_W'(HLT_OPCODE));
  assign in_fetch = (state_q == FETCH);
  assign capture  = in_fetch && !jump_valid && !stall;
  assign advance  = (capture && !is_hlt) || ((state_q == HALT) && resume);

  pc_next_calc #(
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_pc_next_calc (
    .pc_i         (pc_q),
    .jump_valid_i (in_fetch && jump_valid),
    .jump_target_i(jump_target),
    .advance_i    (advance),
    .pc_next_o    (pc_calc),
    .jump_oor_o   (jump_oor)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_calc;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    case (state_q)
      BOOT: begin
        valid_d = 1'b0;
        state_d = FETCH;
      end
      FETCH: begin
        if (jump_valid) begin
          valid_d = 1'b0;
          if (jump_oor) fault_d = 1'b1;
        end else if (!stall) begin
          instr_d  = instrucao;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          if (is_hlt) state_d = HALT;
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (resume) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= ADDR_W'(RESET_PC);
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [ADDR_W-1:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (capture) fetch_cnt_q <= fetch_cnt_q + ADDR_W'(1);
      if (in_fetch && stall && !jump_valid) stall_cnt_q <= stall_cnt_q + ADDR_W'(1);
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

  assign endereco    = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALT);
  assign fault       = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed walk through boot, stall, jump, halt/resume, reset,
// then random stimulus, every cycle compared with a behavioural model of the fetch stage.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 21;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] endereco;
  logic [31:0] instrucao;
  logic        stall, jump_valid, resume;
  logic [31:0] jump_target;
  logic [31:0] instr_out, pc_out;
  logic        instr_valid, halted, fault;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  logic [31:0] mem [0:DEPTH-1];

  always #5 clock = ~clock;

  assign instrucao = (endereco < 32'(DEPTH)) ? mem[endereco[4:0]] : 32'h0;

  instruction_fetch_unit dut (
    .clock      (clock),
    .reset      (reset),
    .endereco   (endereco),
    .instrucao  (instrucao),
    .stall      (stall),
    .jump_valid (jump_valid),
    .jump_target(jump_target),
    .resume     (resume),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .instr_valid(instr_valid),
    .halted     (halted),
    .fault      (fault)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  // Reference model: mode 0 = booting, 1 = fetching, 2 = halted.
  int          m_pc, m_mode, m_pcout, m_valid, m_fault, m_fetch, m_stall;
  logic [31:0] m_iout;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input int imm);
    return {opc, REG_W'(1), IMM_W'(imm)};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mode = 0; m_pcout = 0; m_valid = 0; m_fault = 0;
    m_fetch = 0; m_stall = 0; m_iout = 32'h0;
  endtask

  task automatic model_step(input bit st, input bit jv, input int jt, input bit res);
    logic [31:0] w;
    case (m_mode)
      0: begin
        m_valid = 0;
        m_mode  = 1;
      end
      1: begin
        if (jv) begin
          m_valid = 0;
          if (jt >= DEPTH) begin
            m_pc    = 0;
            m_fault = 1;
          end else begin
            m_pc = jt;
          end
        end else if (st) begin
          m_stall++;
        end else begin
          w       = mem[5'(m_pc)];
          m_iout  = w;
          m_pcout = m_pc;
          m_valid = 1;
          m_fetch++;
          if ((w >> 27) == 32'd18) m_mode = 2;
          else m_pc = (m_pc + 1) % DEPTH;
        end
      end
      default: begin
        m_valid = 0;
        if (res) begin
          m_pc   = (m_pc + 1) % DEPTH;
          m_mode = 1;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("endereco", endereco, 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("pc_out", pc_out, 32'(m_pcout));
    chk("instr_out", instr_out, m_iout);
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("fault", 32'(fault), 32'(m_fault));
`ifdef FETCH_PERF_COUNT_EN
    chk("fetch_count", fetch_count, 32'(m_fetch));
    chk("stall_count", stall_count, 32'(m_stall));
`endif
  endtask

  // Called at a falling edge: drive, advance the model, cross one rising edge, compare.
  task automatic cycle(input bit st, input bit jv, input int jt, input bit res);
    stall       = st;
    jump_valid  = jv;
    jump_target = 32'(jt);
    resume      = res;
    model_step(st, jv, jt, res);
    @(posedge clock);
    @(negedge clock);
    compare_all();
    if (instr_valid) $display("fetch pc=%0d instr=0x%08h", pc_out, instr_out);
  endtask

  task automatic run_until(input int target, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle(0, 0, 0, 0);
      if (m_valid == 1 && m_pcout == target) found = 1;
    end
    if (!found) chk("run_until_pc", pc_out, 32'(target));
  endtask

  initial begin
    logic [4:0] ops [6];
    ops = '{OPC_NOP, OPC_LI, OPC_SW, OPC_OUT, OPC_LR, OPC_HLT};

    reset = 1'b1; stall = 1'b0; jump_valid = 1'b0; jump_target = 32'h0; resume = 1'b0;
    mem[0] = mk(OPC_NOP, 0);
    mem[1] = mk(OPC_LI, 11);
    mem[2] = mk(OPC_SW, 22);
    mem[3] = mk(OPC_OUT, 33);
    mem[4] = mk(OPC_HLT, 44);
    for (int i = 5; i < DEPTH; i++) mem[5'(i)] = mk((i % 2 == 0) ? OPC_LR : OPC_NOP, i);
    model_reset();
    #3;
    compare_all();
    @(negedge clock);
    reset = 1'b0;

    // Run with a 3-cycle stall while pc_out = 2, then on to the halt word.
    run_until(2, 10);
    repeat (3) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("stall_release_pc", pc_out, 32'd3);
    run_until(4, 5);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_addr", endereco, 32'd4);

    // HALT ignores stall and jump; resume restarts at 5 and wraps 20 -> 0.
    repeat (5) cycle(1, 1, 3, 0);
    cycle(0, 0, 0, 1);
    chk("resume_addr", endereco, 32'd5);
    run_until(20, 20);
    cycle(0, 0, 0, 0);
    chk("wrap_pc", pc_out, 32'd0);
    run_until(2, 5);

    // Jump beats a simultaneous stall while endereco = 3.
    cycle(1, 1, 1, 0);
    chk("jump_squash", 32'(instr_valid), 32'd0);
    chk("jump_addr", endereco, 32'd1);
    cycle(0, 0, 0, 0);
    chk("jump_first_pc", pc_out, 32'd1);
    run_until(4, 10);

    // Out-of-range jump: fault, restart from 0, fault stays.
    cycle(0, 0, 0, 1);
    cycle(0, 1, 25, 0);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_addr", endereco, 32'd0);
    run_until(4, 10);
    chk("fault_sticky", 32'(fault), 32'd1);

    // Asynchronous reset between edges while halted.
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b0;
    cycle(0, 0, 0, 0);
    chk("reboot_valid", 32'(instr_valid), 32'd0);
    run_until(0, 3);

    // Random program and random control inputs.
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      mem[5'(i)] = {ops[$urandom_range(0, 5)], 27'($urandom)};
    @(negedge clock);
    model_reset();
    reset = 1'b0;
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 26)), $urandom_range(0, 2) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
